// File: rtl/idma_realign_buffer_if.sv
// idma_realign_buffer_if: read-side and write-side byte-lane handshake bundle of the realignment buffer
interface idma_realign_buffer_if #(
  parameter int StrbWidth  = 8,
  parameter int ShiftWidth = (StrbWidth > 1) ? $clog2(StrbWidth) : 1
);
  logic [8*StrbWidth-1:0] in_data_i;
  logic [StrbWidth-1:0]   in_valid_i;
  logic [StrbWidth-1:0]   in_ready_o;
  logic [ShiftWidth-1:0]  in_shift_i;
  logic [8*StrbWidth-1:0] out_data_o;
  logic [StrbWidth-1:0]   out_valid_o;
  logic [StrbWidth-1:0]   out_ready_i;
  logic [ShiftWidth-1:0]  out_shift_i;
  modport slave (
    input  in_data_i, in_valid_i, in_shift_i, out_ready_i, out_shift_i,
    output in_ready_o, out_data_o, out_valid_o
  );
  modport master (
    output in_data_i, in_valid_i, in_shift_i, out_ready_i, out_shift_i,
    input  in_ready_o, out_data_o, out_valid_o
  );
endinterface

// File: rtl/idma_realign_buffer.sv
// idma_realign_buffer: rotate-in, per-lane FIFO, rotate-out byte realigner; IDMA_REALIGN_FLUSH_EN adds flush_i
module idma_realign_buffer #(
  parameter int StrbWidth   = 8,
  parameter int BufferDepth = 3,
  parameter int ShiftWidth  = (StrbWidth > 1) ? $clog2(StrbWidth) : 1,
  parameter int CntWidth    = $clog2(BufferDepth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef IDMA_REALIGN_FLUSH_EN
  input  logic                 flush_i,
`endif
  idma_realign_buffer_if.slave bus,
  output logic                 busy_o,
  output logic [StrbWidth-1:0] full_o
);
  localparam int ptr_w = (BufferDepth > 2) ? $clog2(BufferDepth) : 1;
  localparam logic [ShiftWidth-1:0] lane_mask = ShiftWidth'(StrbWidth - 1);
  localparam logic [ptr_w-1:0] last = ptr_w'(BufferDepth - 1);
  logic                 clear;
  logic [StrbWidth-1:0] lane_valid, lane_ready, push, pop, nonempty;
  logic [7:0]           in_bytes  [StrbWidth];
  logic [7:0]           lane_data [StrbWidth];
  logic [7:0]           head      [StrbWidth];
`ifdef IDMA_REALIGN_FLUSH_EN
  assign clear = rst_i || flush_i;
`else
  assign clear = rst_i;
`endif
  assign busy_o = |nonempty;
  for (genvar i = 0; i < StrbWidth; i++) begin : g_lane
    localparam logic [ShiftWidth-1:0] li = ShiftWidth'(i);
    logic [7:0]          mem [BufferDepth];
    logic [ptr_w-1:0]    wptr, rptr;
    logic [CntWidth-1:0] cnt;
    assign in_bytes[i]   = bus.in_data_i[8*i +: 8];
    assign lane_valid[i] = bus.in_valid_i[(li + bus.in_shift_i) & lane_mask];
    assign lane_data[i]  = in_bytes[(li + bus.in_shift_i) & lane_mask];
    assign full_o[i]     = cnt == CntWidth'(BufferDepth);
    assign nonempty[i]   = cnt != '0;
    // ready comes from the count alone, so a full lane never passes through
    assign lane_ready[i] = !full_o[i] && !clear;
    assign push[i]       = lane_valid[i] && lane_ready[i];
    assign pop[i]        = nonempty[i] && bus.out_ready_i[(li - bus.out_shift_i) & lane_mask];
    assign head[i]       = mem[rptr];
    assign bus.in_ready_o[i]         = lane_ready[(li - bus.in_shift_i) & lane_mask];
    assign bus.out_valid_o[i]        = nonempty[(li + bus.out_shift_i) & lane_mask];
    assign bus.out_data_o[8*i +: 8]  = head[(li + bus.out_shift_i) & lane_mask];
    always_ff @(posedge clk_i) begin
      if (rst_i) mem <= '{default: '0};
      else if (push[i]) mem[wptr] <= lane_data[i];
      if (clear) begin
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
      end else begin
        if (push[i]) wptr <= (wptr == last) ? '0 : wptr + 1'b1;
        if (pop[i]) rptr <= (rptr == last) ? '0 : rptr + 1'b1;
        cnt <= cnt + CntWidth'(push[i]) - CntWidth'(pop[i]);
      end
    end
  end
endmodule

// File: tb/tb_idma_realign_buffer.sv
// tb_idma_realign_buffer: scoreboard bench for the realignment buffer with StrbWidth=4, BufferDepth=3
module tb_idma_realign_buffer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       busy;
  logic [3:0] full;
  int         checks = 0;
  int         passes = 0;
  logic [7:0] q [4][$];
  idma_realign_buffer_if #(.StrbWidth(4)) bus ();
  idma_realign_buffer #(.StrbWidth(4), .BufferDepth(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
`ifdef IDMA_REALIGN_FLUSH_EN
    .flush_i (flush),
`endif
    .bus    (bus),
    .busy_o (busy),
    .full_o (full)
  );
  always #5 clk = ~clk;

  task automatic cycle();
    int k, j;
    logic [3:0] er, ev, ef, pop_m, push_m;
    logic [7:0] pd [4];
    @(negedge clk);
    er = '0; ev = '0; ef = '0; pop_m = '0; push_m = '0;
    for (int b = 0; b < 4; b++) begin
      pd[b] = '0;
      k = (b + int'(bus.in_shift_i)) % 4;
      j = (b - int'(bus.out_shift_i) + 4) % 4;
      er[k] = !rst && !flush && q[b].size() < 3;
      ef[b] = q[b].size() == 3;
      if (bus.in_valid_i[k] && er[k]) begin
        push_m[b] = 1'b1;
        pd[b] = bus.in_data_i[8*k +: 8];
      end
      ev[j] = q[b].size() != 0;
      if (ev[j]) begin
        checks++;
        if (bus.out_data_o[8*j +: 8] !== q[b][0])
          $display("FAIL sb_data lane%0d got %h want %h", j, bus.out_data_o[8*j +: 8], q[b][0]);
        else passes++;
        if (bus.out_ready_i[j]) pop_m[b] = 1'b1;
      end
    end
    checks++;
    if (bus.in_ready_o !== er) $display("FAIL sb_in_ready got %b want %b", bus.in_ready_o, er);
    else passes++;
    checks++;
    if (bus.out_valid_o !== ev) $display("FAIL sb_out_valid got %b want %b", bus.out_valid_o, ev);
    else passes++;
    checks++;
    if (full !== ef || busy !== (|ev)) $display("FAIL sb_status got full=%b busy=%b want full=%b busy=%b", full, busy, ef, |ev);
    else passes++;
    @(posedge clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      if (rst || flush) q[b].delete();
      else begin
        if (pop_m[b]) void'(q[b].pop_front());
        if (push_m[b]) q[b].push_back(pd[b]);
      end
    end
  endtask

  task automatic drain();
    bus.in_valid_i = '0;
    bus.out_ready_i = 4'hF;
    repeat (5) cycle();
    checks++;
    if (busy !== 1'b0) $display("FAIL drain_busy got %b want 0", busy);
    else passes++;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.in_ready_o !== 4'h0) $display("FAIL reset_in_ready got %b want 0000", bus.in_ready_o);
    else passes++;
    checks++;
    if (bus.out_valid_o !== 4'h0 || busy !== 1'b0 || full !== 4'h0)
      $display("FAIL reset_status got valid=%b busy=%b full=%b want 0", bus.out_valid_o, busy, full);
    else passes++;
    checks++;
    if (bus.out_data_o !== 32'h0) $display("FAIL reset_data got %h want 00000000", bus.out_data_o);
    else passes++;
    rst = 1'b0;
  endtask

  task automatic test_read_rotation();
    bus.in_shift_i = 2'd1; bus.out_shift_i = 2'd0; bus.out_ready_i = 4'h0;
    bus.in_data_i = 32'h44332211; bus.in_valid_i = 4'hF;
    cycle();
    bus.in_valid_i = 4'h0;
    checks++;
    if (bus.out_data_o !== 32'h11443322 || bus.out_valid_o !== 4'hF || busy !== 1'b1)
      $display("FAIL read_rot got data=%h valid=%b busy=%b want 11443322 1111 1", bus.out_data_o, bus.out_valid_o, busy);
    else passes++;
    bus.in_shift_i = 2'd0;
    drain();
  endtask

  task automatic test_write_rotation();
    bus.in_shift_i = 2'd0; bus.out_shift_i = 2'd0; bus.out_ready_i = 4'h0;
    bus.in_data_i = 32'h0000BBAA; bus.in_valid_i = 4'b0011;
    cycle();
    bus.in_valid_i = 4'h0;
    bus.out_shift_i = 2'd2;
    #1;
    checks++;
    if (bus.out_valid_o !== 4'b1100 || bus.out_data_o[31:16] !== 16'hBBAA)
      $display("FAIL write_rot got valid=%b data=%h want 1100 BBAA....", bus.out_valid_o, bus.out_data_o);
    else passes++;
    bus.out_ready_i = 4'b1100;
    cycle();
    checks++;
    if (busy !== 1'b0 || bus.out_valid_o !== 4'h0)
      $display("FAIL write_rot_pop got busy=%b valid=%b want 0 0000", busy, bus.out_valid_o);
    else passes++;
    bus.out_shift_i = 2'd0;
  endtask

  task automatic test_coalesce();
    bus.out_ready_i = 4'h0;
    bus.in_data_i = 32'h0000BBAA; bus.in_valid_i = 4'b0011;
    cycle();
    checks++;
    if (bus.out_valid_o !== 4'b0011) $display("FAIL coalesce_1 got %b want 0011", bus.out_valid_o);
    else passes++;
    bus.in_data_i = 32'hDDCC0000; bus.in_valid_i = 4'b1100;
    cycle();
    checks++;
    if (bus.out_valid_o !== 4'hF || bus.out_data_o !== 32'hDDCCBBAA)
      $display("FAIL coalesce_2 got valid=%b data=%h want 1111 DDCCBBAA", bus.out_valid_o, bus.out_data_o);
    else passes++;
    drain();
  endtask

  task automatic test_full_wrap();
    bus.out_ready_i = 4'h0;
    bus.in_valid_i = 4'hF;
    for (int n = 1; n <= 3; n++) begin
      bus.in_data_i = {4{8'(n)}};
      cycle();
    end
    bus.in_data_i = {4{8'd4}};
    #1;
    checks++;
    if (full !== 4'hF || bus.in_ready_o !== 4'h0)
      $display("FAIL full got full=%b in_ready=%b want 1111 0000", full, bus.in_ready_o);
    else passes++;
    cycle();
    bus.out_ready_i = 4'hF;
    cycle();
    checks++;
    if (bus.out_data_o !== 32'h02020202) $display("FAIL wrap_order got %h want 02020202", bus.out_data_o);
    else passes++;
    cycle();
    bus.in_valid_i = 4'h0;
    repeat (3) cycle();
    checks++;
    if (busy !== 1'b0) $display("FAIL wrap_busy got %b want 0", busy);
    else passes++;
  endtask

  task automatic test_reset_mid();
    bus.out_ready_i = 4'h0;
    bus.in_valid_i = 4'hF;
    bus.in_data_i = 32'hA1A2A3A4;
    repeat (2) cycle();
    rst = 1'b1;
    bus.in_data_i = 32'h5A5A5A5A;
    #1;
    checks++;
    if (bus.in_ready_o !== 4'h0) $display("FAIL rst_mid_ready got %b want 0000", bus.in_ready_o);
    else passes++;
    cycle();
    rst = 1'b0;
    bus.in_valid_i = 4'h0;
    checks++;
    if (bus.out_valid_o !== 4'h0 || busy !== 1'b0)
      $display("FAIL rst_mid_state got valid=%b busy=%b want 0000 0", bus.out_valid_o, busy);
    else passes++;
    cycle();
    checks++;
    if (busy !== 1'b0) $display("FAIL rst_mid_nostore got busy=%b want 0", busy);
    else passes++;
  endtask

`ifdef IDMA_REALIGN_FLUSH_EN
  task automatic test_flush();
    bus.out_ready_i = 4'h0;
    bus.in_valid_i = 4'hF;
    bus.in_data_i = 32'h0F0E0D0C;
    repeat (3) cycle();
    flush = 1'b1;
    bus.out_ready_i = 4'hF;
    #1;
    checks++;
    if (bus.in_ready_o !== 4'h0) $display("FAIL flush_ready got %b want 0000", bus.in_ready_o);
    else passes++;
    cycle();
    flush = 1'b0;
    bus.in_valid_i = 4'h0;
    checks++;
    if (bus.out_valid_o !== 4'h0 || full !== 4'h0 || busy !== 1'b0)
      $display("FAIL flush_state got valid=%b full=%b busy=%b want 0", bus.out_valid_o, full, busy);
    else passes++;
  endtask
`endif

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      bus.in_valid_i  = 4'($urandom_range(0, 15));
      bus.in_data_i   = $urandom;
      bus.in_shift_i  = 2'($urandom_range(0, 3));
      bus.out_shift_i = 2'($urandom_range(0, 3));
      bus.out_ready_i = (n % 50 < 10) ? 4'h0 : 4'($urandom_range(0, 15));
      cycle();
    end
    drain();
  endtask

  initial begin
    bus.in_data_i = '0; bus.in_valid_i = '0; bus.in_shift_i = '0;
    bus.out_ready_i = '0; bus.out_shift_i = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_read_rotation();
    test_write_rotation();
    test_coalesce();
    test_full_wrap();
    test_reset_mid();
`ifdef IDMA_REALIGN_FLUSH_EN
    test_flush();
`endif
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
